// File: rtl/seg_pkg.sv
// Shared constants, types and helpers for the 4-digit multiplexed
// seven-segment scan controller.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned DIGITS_W   = NUM_DIGITS * BCD_W;

  localparam logic [3:0] SEL_D0    = 4'b0001;
  localparam logic [3:0] SEL_D1    = 4'b0010;
  localparam logic [3:0] SEL_D2    = 4'b0100;
  localparam logic [3:0] SEL_D3    = 4'b1000;
  localparam logic [3:0] SEL_BLANK = 4'b0000;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_SLOT0 = 3'd1,
    ST_SLOT1 = 3'd2,
    ST_SLOT2 = 3'd3,
    ST_SLOT3 = 3'd4
  } slot_state_t;

  // Per-frame copy of every display input, so a frame never tears.
  typedef struct packed {
    logic [DIGITS_W-1:0] digits;
    logic                lz_blank;
    logic [3:0]          dp_mask;
    logic [3:0]          blink_mask;
  } snap_t;

  function automatic logic [3:0] slot_sel(input logic [1:0] idx);
    logic [3:0] sel;
    case (idx)
      2'd0:    sel = SEL_D0;
      2'd1:    sel = SEL_D1;
      2'd2:    sel = SEL_D2;
      2'd3:    sel = SEL_D3;
      default: sel = SEL_BLANK;
    endcase
    return sel;
  endfunction

  // True when digit idx and every digit above it are zero; digit 0 always shows.
  function automatic logic lz_hidden(input logic [DIGITS_W-1:0] d, input logic [1:0] idx);
    logic hide;
    case (idx)
      2'd3:    hide = (d[15:12] == 4'd0);
      2'd2:    hide = (d[15:8] == 8'd0);
      2'd1:    hide = (d[15:4] == 12'd0);
      default: hide = 1'b0;
    endcase
    return hide;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle between the scan controller and whoever drives it.
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic                en;
  logic [DIGITS_W-1:0] digits;
  logic                lz_blank;
  logic [3:0]          dp_mask;
  logic [3:0]          blink_mask;
  logic [3:0]          side;
  logic [3:0]          num_now;
  logic                dp;
  logic                frame_start;

  modport master (
    output en, digits, lz_blank, dp_mask, blink_mask,
    input  side, num_now, dp, frame_start
  );

  modport slave (
    input  en, digits, lz_blank, dp_mask, blink_mask,
    output side, num_now, dp, frame_start
  );

endinterface

// File: rtl/seg_tick_div.sv
// Modulo-DIV event counter: counts enabled cycles, pulses tick on the last
// count and wraps. Holds its count while en=0; only rst clears it.
module seg_tick_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  // next count
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = cnt_q;
    end else if (cnt_q == LAST) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display scanner: slot sequencing, per-frame input
// snapshot, leading-zero blanking and blink, with fully registered outputs.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  slot_state_t state_q, state_d;
  snap_t       snap_q, snap_d;
  logic        phase_q, phase_d;
  logic [3:0]  side_q, side_d;
  logic [3:0]  num_q, num_d;
  logic        dp_q, dp_d;
  logic        fs_q, fs_d;

  logic        run_s;
  logic        pre_rst_s;
  logic        slot_tick_s;
  logic        frame_done_s;
  logic        blink_tick_s;
  logic        start_s;
  logic [1:0]  idx_s;
  logic        act_s;
  logic        blank_s;

  // The prescaler only runs once a slot is live, so slot 0 gets its full
  // length after the OFF->SLOT0 edge; dropping en clears it immediately.
  assign run_s     = bus.en && (state_q != ST_OFF);
  assign pre_rst_s = rst || !run_s;

  seg_tick_div #(.DIV(SCAN_DIV)) u_slot_div (
    .clk  (clk),
    .rst  (pre_rst_s),
    .en   (run_s),
    .tick (slot_tick_s)
  );

  assign frame_done_s = slot_tick_s && (state_q == ST_SLOT3);

  seg_tick_div #(.DIV(BLINK_FRAMES)) u_blink_div (
    .clk  (clk),
    .rst  (rst),
    .en   (frame_done_s),
    .tick (blink_tick_s)
  );

  assign start_s = bus.en && ((state_q == ST_OFF) || frame_done_s);

  // slot FSM, snapshot and blink phase
  always_comb begin
    state_d = state_q;
    if (!bus.en) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:   state_d = ST_SLOT0;
        ST_SLOT0: state_d = slot_tick_s ? ST_SLOT1 : ST_SLOT0;
        ST_SLOT1: state_d = slot_tick_s ? ST_SLOT2 : ST_SLOT1;
        ST_SLOT2: state_d = slot_tick_s ? ST_SLOT3 : ST_SLOT2;
        ST_SLOT3: state_d = slot_tick_s ? ST_SLOT0 : ST_SLOT3;
        default:  state_d = ST_OFF;
      endcase
    end

    if (start_s) begin
      snap_d = '{digits: bus.digits, lz_blank: bus.lz_blank,
                 dp_mask: bus.dp_mask, blink_mask: bus.blink_mask};
    end else begin
      snap_d = snap_q;
    end

    if (blink_tick_s) begin
      phase_d = ~phase_q;
    end else begin
      phase_d = phase_q;
    end
  end

  // Outputs are computed from next-state values so they register in step
  // with the slot they belong to.
  always_comb begin
    idx_s = 2'd0;
    act_s = 1'b1;
    case (state_d)
      ST_SLOT0: idx_s = 2'd0;
      ST_SLOT1: idx_s = 2'd1;
      ST_SLOT2: idx_s = 2'd2;
      ST_SLOT3: idx_s = 2'd3;
      default:  act_s = 1'b0;
    endcase

    blank_s = (snap_d.lz_blank && lz_hidden(snap_d.digits, idx_s)) ||
              (phase_d && snap_d.blink_mask[idx_s]);

    if (act_s && !blank_s) begin
      side_d = slot_sel(idx_s);
      num_d  = snap_d.digits[{idx_s, 2'b00} +: 4];
      dp_d   = snap_d.dp_mask[idx_s];
    end else begin
      side_d = SEL_BLANK;
      num_d  = 4'd0;
      dp_d   = 1'b0;
    end
    fs_d = start_s;
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      snap_q  <= snap_t'(25'd0);
      phase_q <= 1'b0;
      side_q  <= SEL_BLANK;
      num_q   <= 4'd0;
      dp_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      phase_q <= phase_d;
      side_q  <= side_d;
      num_q   <= num_d;
      dp_q    <= dp_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.side        = side_q;
  assign bus.num_now     = num_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  seg_scan_ctrl_if bus_if ();

  seg_scan_ctrl #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dark(input string tag);
    check_eq({tag, " side"}, {28'd0, bus_if.side}, 32'h0);
    check_eq({tag, " num"}, {28'd0, bus_if.num_now}, 32'h0);
    check_eq({tag, " dp"}, {31'd0, bus_if.dp}, 32'h0);
    check_eq({tag, " fs"}, {31'd0, bus_if.frame_start}, 32'h0);
  endtask

  // Checks ncyc cycles of a frame starting at the next edge. sides/nums hold
  // the expected per-slot value, slot i in bits [4i+3:4i]; dps bit i is slot i.
  // Optionally changes digits after cycle chg_cyc to probe snapshot behaviour.
  task automatic run_frame(input string tag, input logic [15:0] sides,
                           input logic [15:0] nums, input logic [3:0] dps,
                           input int ncyc, input int chg_cyc, input logic [15:0] chg_digits);
    for (int c = 0; c < ncyc; c++) begin
      int s;
      @(negedge clk);
      s = c / 4;
      check_eq($sformatf("%s c%0d side", tag, c), {28'd0, bus_if.side}, {28'd0, sides[s*4 +: 4]});
      check_eq($sformatf("%s c%0d num", tag, c), {28'd0, bus_if.num_now}, {28'd0, nums[s*4 +: 4]});
      check_eq($sformatf("%s c%0d dp", tag, c), {31'd0, bus_if.dp}, {31'd0, dps[s]});
      check_eq($sformatf("%s c%0d fs", tag, c), {31'd0, bus_if.frame_start}, {31'd0, (c == 0)});
      if (c == chg_cyc) bus_if.digits = chg_digits;
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus_if.en         = 1'b0;
    bus_if.digits     = 16'h0000;
    bus_if.lz_blank   = 1'b0;
    bus_if.dp_mask    = 4'b0000;
    bus_if.blink_mask = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check_dark("reset");

    // rst wins over en
    bus_if.en     = 1'b1;
    bus_if.digits = 16'h1234;
    @(negedge clk);
    check_dark("rst_prio");
    rst = 1'b0;

    // frames 1-2: plain scan of 1234
    run_frame("f1", 16'h8421, 16'h1234, 4'b0000, 16, -1, 16'h0);
    run_frame("f2", 16'h8421, 16'h1234, 4'b0000, 16, -1, 16'h0);

    // frames 3-4: leading-zero blanking
    bus_if.digits   = 16'h0050;
    bus_if.lz_blank = 1'b1;
    run_frame("lz0050", 16'h0021, 16'h0050, 4'b0000, 16, -1, 16'h0);
    bus_if.digits = 16'h0000;
    run_frame("lz0000", 16'h0001, 16'h0000, 4'b0000, 16, -1, 16'h0);

    // frames 5-6: mid-frame change is deferred to the next frame
    bus_if.lz_blank = 1'b0;
    bus_if.digits   = 16'h1234;
    run_frame("tear", 16'h8421, 16'h1234, 4'b0000, 16, 6, 16'h5678);
    run_frame("next", 16'h8421, 16'h5678, 4'b0000, 16, -1, 16'h0);

    // frames 7-11: blink on digits 0/1 (phase=1 for frames 7,8,11), dp on digit 2
    bus_if.digits     = 16'h1234;
    bus_if.blink_mask = 4'b0011;
    bus_if.dp_mask    = 4'b0100;
    run_frame("blk7", 16'h8400, 16'h1200, 4'b0100, 16, -1, 16'h0);
    run_frame("blk8", 16'h8400, 16'h1200, 4'b0100, 16, -1, 16'h0);
    run_frame("blk9", 16'h8421, 16'h1234, 4'b0100, 16, -1, 16'h0);
    run_frame("blk10", 16'h8421, 16'h1234, 4'b0100, 16, -1, 16'h0);
    run_frame("blk11", 16'h8400, 16'h1200, 4'b0100, 16, -1, 16'h0);

    // frame 12 (phase=1, masks off): drop en in slot 2 for 5 cycles
    bus_if.blink_mask = 4'b0000;
    bus_if.dp_mask    = 4'b0000;
    run_frame("pre_off", 16'h8421, 16'h1234, 4'b0000, 10, -1, 16'h0);
    bus_if.en         = 1'b0;
    bus_if.blink_mask = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_dark($sformatf("off%0d", k));
    end
    bus_if.en = 1'b1;
    // phase and frame count held: this frame is still phase=1, then toggles
    run_frame("restart", 16'h8400, 16'h1200, 4'b0000, 16, -1, 16'h0);
    run_frame("after", 16'h8421, 16'h1234, 4'b0000, 16, -1, 16'h0);

    // reset in slot 3: next frames restart with phase=0 and a cleared frame count
    run_frame("pre_rst", 16'h8421, 16'h1234, 4'b0000, 14, -1, 16'h0);
    rst = 1'b1;
    @(negedge clk);
    check_dark("mid_rst");
    rst = 1'b0;
    run_frame("rst_f1", 16'h8421, 16'h1234, 4'b0000, 16, -1, 16'h0);
    run_frame("rst_f2", 16'h8421, 16'h1234, 4'b0000, 16, -1, 16'h0);
    run_frame("rst_f3", 16'h8400, 16'h1200, 4'b0000, 16, -1, 16'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
